// File: rtl/sharpen_seq.sv
// Memory-side sequencer for the 4-pixel sharpen datapath: fetches up/mid/down
// row words for each source word, sharpens them and writes the result word out.

module sharpen_unit (
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] up_row,
    output logic [31:0] rd
);
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_px
            // Byte 0 sits in [31:24]; edge neighbours mirror back into the word.
            localparam int LI = (gi == 0) ? 1 : gi - 1;
            localparam int RI = (gi == 3) ? 2 : gi + 1;

            logic [11:0]        m12, l12, r12, u12, d12;
            logic signed [11:0] acc;

            assign m12 = {4'b0000, rs1[31-8*gi -: 8]};
            assign l12 = {4'b0000, rs1[31-8*LI -: 8]};
            assign r12 = {4'b0000, rs1[31-8*RI -: 8]};
            assign u12 = {4'b0000, up_row[31-8*gi -: 8]};
            assign d12 = {4'b0000, rs2[31-8*gi -: 8]};
            // Result spans -1020..1275, so 12-bit wraparound arithmetic is exact.
            assign acc = $signed((m12 << 2) + m12 - l12 - r12 - u12 - d12);
            assign rd[31-8*gi -: 8] = acc[11] ? 8'h00 :
                                      ((acc > 12'sd255) ? 8'hFF : acc[7:0]);
        end
    endgenerate
endmodule

module sharpen_seq #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_base,
    input  logic [ADDR_W-1:0]    dst_base,
    input  logic [DIM_W-1:0]     width_words,
    input  logic [DIM_W-1:0]     height_rows,
    output logic                 busy,
    output logic                 done,
    output logic [2*DIM_W-1:0]   words_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack
);
    typedef enum logic [2:0] {IDLE, RD_UP, RD_MID, RD_DN, WR, DONE} state_t;

    localparam logic [2*DIM_W-1:0] WD_ONE = 1;

    state_t              state_reg;
    logic [DIM_W-1:0]    w_reg, h_reg, r_reg, c_reg;
    logic [ADDR_W-1:0]   stride_reg, src_row_reg, dst_row_reg, col_off_reg;
    logic [31:0]         up_reg, mid_reg, dn_reg;

    logic                last_col, last_row, single_row;
    logic [DIM_W-1:0]    adv_r, adv_c;
    logic [ADDR_W-1:0]   adv_src_row, adv_dst_row, adv_col_off;
    logic [ADDR_W-1:0]   mid_addr, dn_addr, wr_addr, up_addr_next;
    logic [ADDR_W-1:0]   start_stride, start_up_addr;
    logic [31:0]         dp_dn, dp_out;

    always_comb begin
        last_col    = (c_reg == w_reg - DIM_W'(1));
        last_row    = (r_reg == h_reg - DIM_W'(1));
        single_row  = (h_reg == DIM_W'(1));
        adv_r       = last_col ? r_reg + DIM_W'(1) : r_reg;
        adv_c       = last_col ? '0 : c_reg + DIM_W'(1);
        adv_src_row = last_col ? src_row_reg + stride_reg : src_row_reg;
        adv_dst_row = last_col ? dst_row_reg + stride_reg : dst_row_reg;
        adv_col_off = last_col ? '0 : col_off_reg + ADDR_W'(4);

        mid_addr = src_row_reg + col_off_reg;
        wr_addr  = dst_row_reg + col_off_reg;
        // Bottom row mirrors down to row H-2 (or itself for a one-row image).
        if (!last_row)
            dn_addr = mid_addr + stride_reg;
        else if (single_row)
            dn_addr = mid_addr;
        else
            dn_addr = mid_addr - stride_reg;

        if (adv_r != '0)
            up_addr_next = adv_src_row + adv_col_off - stride_reg;
        else if (single_row)
            up_addr_next = adv_src_row + adv_col_off;
        else
            up_addr_next = adv_src_row + adv_col_off + stride_reg;

        start_stride  = {{(ADDR_W-DIM_W-2){1'b0}}, width_words, 2'b00};
        start_up_addr = (height_rows == DIM_W'(1)) ? src_base : src_base + start_stride;

        // The down word arrives in the same cycle the result is registered.
        dp_dn = (state_reg == RD_DN) ? mem_rdata : dn_reg;
    end

    sharpen_unit u_dp (
        .rs1    (mid_reg),
        .rs2    (dp_dn),
        .up_row (up_reg),
        .rd     (dp_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            words_done  <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            w_reg       <= '0;
            h_reg       <= '0;
            r_reg       <= '0;
            c_reg       <= '0;
            stride_reg  <= '0;
            src_row_reg <= '0;
            dst_row_reg <= '0;
            col_off_reg <= '0;
            up_reg      <= '0;
            mid_reg     <= '0;
            dn_reg      <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        w_reg       <= width_words;
                        h_reg       <= height_rows;
                        stride_reg  <= start_stride;
                        src_row_reg <= src_base;
                        dst_row_reg <= dst_base;
                        col_off_reg <= '0;
                        r_reg       <= '0;
                        c_reg       <= '0;
                        words_done  <= '0;
                        busy        <= 1'b1;
                        if (width_words == '0 || height_rows == '0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= RD_UP;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= start_up_addr;
                        end
                    end
                end
                RD_UP: begin
                    if (mem_ack) begin
                        up_reg    <= mem_rdata;
                        mem_addr  <= mid_addr;
                        state_reg <= RD_MID;
                    end
                end
                RD_MID: begin
                    if (mem_ack) begin
                        mid_reg   <= mem_rdata;
                        mem_addr  <= dn_addr;
                        state_reg <= RD_DN;
                    end
                end
                RD_DN: begin
                    if (mem_ack) begin
                        dn_reg    <= mem_rdata;
                        mem_wdata <= dp_out;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        state_reg <= WR;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        words_done <= words_done + WD_ONE;
                        mem_we     <= 1'b0;
                        if (last_col && last_row) begin
                            mem_req   <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            r_reg       <= adv_r;
                            c_reg       <= adv_c;
                            src_row_reg <= adv_src_row;
                            dst_row_reg <= adv_dst_row;
                            col_off_reg <= adv_col_off;
                            mem_addr    <= up_addr_next;
                            state_reg   <= RD_UP;
                        end
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sharpen_seq.md
Name: sharpen_seq

Overview:
- Memory-side sequencer for the 4-pixel sharpen datapath (`sharpen_unit`, instantiated inside this block).
- Walks a source image of packed 8-bit pixels, 4 per 32-bit word, row-major, word by word.
- For each word: fetches the up, mid and down row words, feeds them to the datapath, writes the result word to a destination buffer.
- Started by the DLX core through configuration inputs; owns one single-port memory master interface.

Parameters:
ADDR_W, 32, byte-address width of memory interface and base registers
DIM_W, 12, width of width_words / height_rows counters

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin; sampled only in IDLE
src_base  input  ADDR_W  byte address of pixel word (row 0, col 0) of source; word aligned
dst_base  input  ADDR_W  byte address of destination word (0,0); word aligned
width_words  input  DIM_W  words per row (pixels/4)
height_rows  input  DIM_W  number of rows
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse at completion
words_done  output  2*DIM_W  count of result words written in current/last operation
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  byte address of access
mem_wdata  output  32  write data (sharpen result)
mem_rdata  input  32  read data, valid in ack cycle
mem_ack  input  1  access complete; meaningful only while mem_req high

Behaviour:
- Reset (synchronous, active-high, any state, including mid-access): state=IDLE. busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, words_done=0. Pending access is abandoned; no further memory activity.
- Config capture: src_base, dst_base, width_words and height_rows are latched on an accepted start. Later input changes are ignored until the next start.
- start outside IDLE is ignored.
- States: IDLE, RD_UP, RD_MID, RD_DN, WR, DONE.
  - IDLE + start, width or height = 0: go to DONE; no memory access; words_done=0.
  - IDLE + start, otherwise: words_done cleared, r=0, c=0, go to RD_UP.
  - RD_UP → RD_MID → RD_DN → WR: each advances on the cycle mem_ack=1; read data is captured into up_reg, mid_reg or dn_reg respectively.
  - WR on ack: words_done+1. If last word (r=H-1, c=W-1), go to DONE; else advance c (wrap to 0, r+1) and go to RD_UP.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE; it is 0 in the cycle after DONE.
- Handshake:
  - mem_req is asserted in RD_*/WR.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and ack=0.
  - Ack may arrive in the same cycle as req (zero wait).
  - mem_req may stay high across back-to-back accesses; addr changes only after an ack.
- Addressing: rowaddr(r) = base + r*W*4, computed incrementally with no multiplier; word (r,c) is at rowaddr(r) + 4c.
  - RD_UP reads src word (r-1,c).
  - RD_MID reads src word (r,c).
  - RD_DN reads src word (r+1,c).
  - WR writes dst word (r,c).
- Vertical reflection:
  - r=0: up row = row 1.
  - r=H-1: down row = row H-2.
  - H=1: up=down=row 0.
  - Reflection matches the datapath's horizontal reflection.
- Datapath: rs1=mid_reg, rs2=dn_reg, up_row=up_reg. mem_wdata = datapath output, registered on entry to WR.
  - Per byte: 5*mid - left - right - up - down, signed, clamped to 0..255.
  - Byte 0 is [31:24]; the left neighbour of byte 0 and the right neighbour of byte 3 reflect within the word.
- Throughput: 4 accesses per word. With zero-wait ack, start at cycle 0 gives the first mem_req at cycle 1 and done at cycle 4*W*H+1.
- Overlap of src and dst regions is undefined; software must keep them disjoint.

Test Plan:
1. Flat image: W=1, H=1, src word 0x80808080, zero-wait ack.
   - Reads at src, src, src; write 0x80808080 to dst.
   - done at cycle 5; words_done=1.
2. Vertical reflection and clamp low: W=1, H=3, rows 0x00000000 / 0x40404040 / 0x00000000.
   - Writes 0x00000000, 0xC0C0C0C0, 0x00000000 at dst, dst+4, dst+8.
   - Row-0 read addresses src+4, src, src+4.
   - Row-2 read addresses src+4, src+8, src+4.
3. Clamp high and row wrap: W=2, H=2, mid words 0xFF00FF00, other words 0.
   - Per word: byte0 = 5*255-0-0-0-0 → 0xFF; byte1 = 0-255-255 → 0x00.
   - Column order is (0,0), (0,1), (1,0), (1,1); words_done=4.
4. Wait states: ack delayed 3 cycles on every access.
   - mem_req, mem_addr, mem_we and mem_wdata stay stable throughout each wait.
   - Results are identical to the zero-wait run.
   - Second start during busy is ignored.
5. Degenerate: start with width_words=0.
   - done next cycle; mem_req never asserted; words_done=0.
6. Reset mid-operation: assert reset during RD_DN with ack pending.
   - Next cycle: all outputs at reset values, no further mem_req.
   - A new start runs a clean complete pass.
